// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
//   Iterative multiply/divide unit with HI/LO result registers, executing
//   MULTU/MULT/DIVU/DIV in WIDTH cycles (radix-2 shift-add multiply,
//   restoring divide). It sits beside the ALU in the execute stage. busy
//   stalls the pipeline. HI/LO feed the MFHI/MFLO writeback path.
//
//   Optional feature macro: MULDIV_SIGNED_EN
//     defined   : op[0]=1 selects signed MULT/DIV. Operands are converted to
//                 magnitudes when the operation starts, and the result sign
//                 is fixed when it commits.
//     undefined : op[0] is ignored. MULT runs as MULTU and DIV runs as DIVU.
//
// Ports
//   Clk          in   clock, rising edge
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle request, accepted only in IDLE or DONE
//   op           in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A, B         in   multiplicand/dividend, multiplier/divisor
//   mthi, mtlo   in   write A into HI / LO (ignored while busy or on start)
//   busy         out  operation in progress (stall request)
//   done         out  one-cycle pulse; HI/LO hold the new result
//   div_by_zero  out  set with done when a divide had B==0
//   HI, LO       out  result registers
//
// Handshake: start is a single-cycle request with no ready signal. It is
// accepted on any edge where the unit is not busy. A request made while busy
// is dropped, not queued. Completion is signalled by done for one cycle.
// ---------------------------------------------------------------------------
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     opnd;      // multiplicand (mult) or divisor (div)
  logic [2*WIDTH-1:0]   acc;       // mult: {partial, multiplier}; div: {rem, quot}
  logic                 is_div;
  logic                 dbz_pend;  // published on div_by_zero at commit
  logic                 neg_lo;    // negate product (mult) or quotient (div)
  logic                 neg_hi;    // negate remainder (div)

  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       trial;
  logic [2*WIDTH-1:0]   acc_step;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic                 sgn_lo;
  logic                 sgn_hi;

  // Operand magnitudes and the sign flags that are latched at start.
`ifdef MULDIV_SIGNED_EN
  always_comb begin
    mag_a  = (op[0] && A[WIDTH-1]) ? (~A + 1'b1) : A;
    mag_b  = (op[0] && B[WIDTH-1]) ? (~B + 1'b1) : B;
    // The quotient sign is not flipped on a divide by zero. HI then comes
    // back as -|A| == A and LO as all ones, the same as for DIVU.
    sgn_lo = op[0] && (A[WIDTH-1] ^ B[WIDTH-1]) && !(op[1] && (B == '0));
    sgn_hi = op[0] && op[1] && A[WIDTH-1];
  end
`else
  logic unused_op0;
  assign unused_op0 = op[0];
  always_comb begin
    mag_a  = A;
    mag_b  = B;
    sgn_lo = 1'b0;
    sgn_hi = 1'b0;
  end
`endif

  // One iteration of the shift-add multiply or restoring divide.
  always_comb begin
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    // Trial subtract on the left-shifted remainder. Bit WIDTH set means a borrow.
    trial   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (is_div) begin
      if (!trial[WIDTH]) acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else               acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_step = {add_sum, acc[WIDTH-1:1]};
      else        acc_step = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Final sign fix on the last iteration's value.
`ifdef MULDIV_SIGNED_EN
  logic [2*WIDTH-1:0] prod_fix;
  always_comb begin
    prod_fix = neg_lo ? (~acc_step + 1'b1) : acc_step;
    if (is_div) begin
      res_hi = neg_hi ? (~acc_step[2*WIDTH-1:WIDTH] + 1'b1) : acc_step[2*WIDTH-1:WIDTH];
      res_lo = neg_lo ? (~acc_step[WIDTH-1:0] + 1'b1) : acc_step[WIDTH-1:0];
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end
`else
  logic unused_sign;
  assign unused_sign = neg_lo ^ neg_hi;
  always_comb begin
    res_hi = acc_step[2*WIDTH-1:WIDTH];
    res_lo = acc_step[WIDTH-1:0];
  end
`endif

  always_ff @(posedge Clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      opnd        <= '0;
      acc         <= '0;
      is_div      <= 1'b0;
      dbz_pend    <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      HI          <= '0;
      LO          <= '0;
    end else begin
      case (state)
        S_RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH-1)) begin
            HI          <= res_hi;
            LO          <= res_lo;
            div_by_zero <= dbz_pend;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= S_DONE;
          end
        end
        default: begin  // S_IDLE, S_DONE
          if (start) begin
            // A start takes priority over mthi/mtlo in the same cycle.
            state       <= S_RUN;
            cnt         <= '0;
            is_div      <= op[1];
            opnd        <= op[1] ? mag_b : mag_a;
            acc         <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            dbz_pend    <= op[1] && (B == '0);
            neg_lo      <= sgn_lo;
            neg_hi      <= sgn_hi;
            div_by_zero <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
          end else begin
            state <= S_IDLE;
            done  <= 1'b0;
            if (mthi) HI <= A;
            if (mtlo) LO <= A;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
//   Self-checking bench for mult_div_unit. Expected HI/LO/div_by_zero values
//   come from a plain-arithmetic reference model. Expected results are queued
//   when an operation is launched and popped when done is seen. The bench
//   follows the MULDIV_SIGNED_EN macro, so it matches either build.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        Clk = 1'b0;
  logic        reset, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] A, B;
  logic        busy, done, div_by_zero;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  logic [64:0] exp_q[$];     // {div_by_zero, HI, LO}
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .Clk(Clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .mthi(mthi), .mtlo(mtlo), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .HI(HI), .LO(LO)
  );

  // ---- clock / reset ----
  always #5 Clk = ~Clk;

  // ---- reference model ----
  function automatic logic [64:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sa, sb, q, r;
    logic [31:0] hi, lo;
    logic        dz;
    dz = 1'b0;
    sa = longint'(int'(a));
    sb = longint'(int'(b));
`ifdef MULDIV_SIGNED_EN
    if (o[0]) begin
      if (!o[1]) begin
        p  = 64'(sa * sb);
        hi = p[63:32];
        lo = p[31:0];
      end else if (b == 32'd0) begin
        dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
      end else begin
        q  = sa / sb;
        r  = sa % sb;
        lo = q[31:0];
        hi = r[31:0];
      end
      return {dz, hi, lo};
    end
`endif
    if (!o[1]) begin
      p  = {32'd0, a} * {32'd0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 32'd0) begin
      dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
    end else begin
      hi = a % b;
      lo = a / b;
    end
    return {dz, hi, lo};
  endfunction

  // ---- driver tasks ----
  // Called at 1 time unit after a rising edge. Returns 1 unit after the
  // edge that sampled start, with the operands scrambled.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit with_mt);
    op = o; A = a; B = b; start = 1'b1;
    mthi = with_mt; mtlo = with_mt;
    exp_q.push_back(model(o, a, b));
    @(posedge Clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    op = 2'($urandom); A = $urandom; B = $urandom;
  endtask

  task automatic finish_op(input string tag, input bit poke);
    int          lat;
    int          busy_cnt;
    logic [64:0] exp;
    lat = 0; busy_cnt = 0;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    exp = exp_q.pop_front();
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cnt++;
      if (lat == 3) begin
        checks++;
        if (HI !== model_hi || LO !== model_lo || div_by_zero !== 1'b0) begin
          errors++;
          $display("FAIL %s_hold_during_run HI=%h LO=%h dbz=%b expected HI=%h LO=%h dbz=0",
                   tag, HI, LO, div_by_zero, model_hi, model_lo);
        end
      end
      if (poke && lat == 5) begin
        start = 1'b1; mthi = 1'b1; mtlo = 1'b1; A = $urandom; B = $urandom;
      end
      @(posedge Clk); #1;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
      lat++;
    end
    checks++;
    if (lat != 32) begin
      errors++;
      $display("FAIL %s_latency edges=%0d expected 32", tag, lat);
    end
    checks++;
    if (busy_cnt != 32) begin
      errors++;
      $display("FAIL %s_busy_cycles got=%0d expected 32", tag, busy_cnt);
    end
    checks++;
    if ({div_by_zero, HI, LO} !== exp) begin
      errors++;
      $display("FAIL %s_result dbz=%b HI=%h LO=%h expected dbz=%b HI=%h LO=%h",
               tag, div_by_zero, HI, LO, exp[64], exp[63:32], exp[31:0]);
    end
    model_hi = exp[63:32];
    model_lo = exp[31:0];
  endtask

  task automatic run_vec(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
    launch(o, a, b, 1'b0);
    finish_op(tag, 1'b0);
    checks++;
    if (HI !== ehi || LO !== elo || div_by_zero !== edz) begin
      errors++;
      $display("FAIL %s_const HI=%h LO=%h dbz=%b expected HI=%h LO=%h dbz=%b",
               tag, HI, LO, div_by_zero, ehi, elo, edz);
    end
  endtask

  // ---- scenarios ----
  task automatic test_reset();
    reset = 1'b1; start = 0; mthi = 0; mtlo = 0; op = 0; A = 0; B = 0;
    repeat (3) @(posedge Clk);
    #1 reset = 1'b0;
    checks++;
    if (busy !== 0 || done !== 0 || div_by_zero !== 0 || HI !== 0 || LO !== 0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b dbz=%b HI=%h LO=%h expected all zero",
               busy, done, div_by_zero, HI, LO);
    end
  endtask

  task automatic test_vectors();
    run_vec("multu_7x6", 2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);
    run_vec("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_vec("divu_100_7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_vec("divu_by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
`ifdef MULDIV_SIGNED_EN
    run_vec("mult_m3x5", 2'b01, -32'sd3, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    run_vec("div_m7_2", 2'b11, -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_vec("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
    run_vec("div_s_by0", 2'b11, -32'sd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
`else
    run_vec("mult_m3x5_u", 2'b01, -32'sd3, 32'd5, 32'd4, 32'hFFFF_FFF1, 1'b0);
    run_vec("div_as_divu", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'd1, 32'h7FFF_FFFC, 1'b0);
`endif
  endtask

  task automatic test_mthi_mtlo();
    logic [31:0] v1, v2;
    v1 = $urandom; v2 = $urandom;
    A = v1; mthi = 1'b1;
    @(posedge Clk); #1 mthi = 1'b0;
    A = v2; mtlo = 1'b1;
    @(posedge Clk); #1 mtlo = 1'b0;
    A = $urandom;
    @(posedge Clk); #1;
    checks++;
    if (HI !== v1 || LO !== v2) begin
      errors++;
      $display("FAIL mthi_mtlo HI=%h LO=%h expected HI=%h LO=%h", HI, LO, v1, v2);
    end
    model_hi = v1; model_lo = v2;
  endtask

  // mthi/mtlo alongside start, and start/mthi/mtlo pokes mid-run, must be ignored.
  task automatic test_ignored_requests();
    launch(2'b00, $urandom, $urandom, 1'b1);
    finish_op("start_wins", 1'b0);
    launch(2'b10, $urandom, $urandom_range(1, 1000), 1'b0);
    finish_op("poke_in_run", 1'b1);
  endtask

  task automatic test_back_to_back();
    launch(2'b10, $urandom, 32'd0, 1'b0);
    finish_op("b2b_first", 1'b0);
    // Still in the done cycle: this start is sampled on the very next edge.
    launch(2'b00, $urandom, $urandom, 1'b0);
    finish_op("b2b_second", 1'b0);
    launch(2'b11, $urandom, $urandom, 1'b0);
    finish_op("b2b_third", 1'b0);
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    launch(2'b10, $urandom, $urandom_range(1, 50), 1'b0);
    void'(exp_q.pop_back());
    repeat (9) @(posedge Clk);
    #1 reset = 1'b1;
    @(posedge Clk); #1 reset = 1'b0;
    model_hi = '0; model_lo = '0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      @(posedge Clk); #1;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_done active_cycles=%0d expected 0", seen);
    end
    A = 32'd9; mtlo = 1'b1;
    @(posedge Clk); #1 mtlo = 1'b0;
    checks++;
    if (HI !== 32'd0 || LO !== 32'd9) begin
      errors++;
      $display("FAIL abort_mtlo HI=%h LO=%h expected HI=00000000 LO=00000009", HI, LO);
    end
    model_lo = 32'd9;
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [1:0]  o;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      launch(o, a, b, 1'($urandom_range(0, 1)));
      finish_op($sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge Clk);
      #0;
    end
  endtask

  // ---- sequence and report ----
  initial begin
    test_reset();
    test_vectors();
    test_mthi_mtlo();
    test_ignored_requests();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit in case a wait goes wrong.
  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

endmodule
